// File: rtl/alu_mul_sequencer_if.sv
// Control-side handshake between the control unit and the multiply sequencer.
interface alu_mul_sequencer_if;
  logic        Start;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Ready;
  logic        Done;
  logic [31:0] Product;
  logic        Overflow;

  // Control unit: issues requests, consumes results.
  modport master (
    output Start, OpA, OpB,
    input  Ready, Done, Product, Overflow
  );

  // Sequencer: accepts requests, returns results.
  modport slave (
    input  Start, OpA, OpB,
    output Ready, Done, Product, Overflow
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 unsigned multiplier that steps the shared ALU through
// add/LSL operations and returns the low product word plus an exact overflow.
module alu_mul_sequencer (
  input  logic                 Clock,
  input  logic                 Reset,
  alu_mul_sequencer_if.slave   ctl,
  output logic [31:0]          AluA,
  output logic [31:0]          AluB,
  output logic [4:0]           AluFunSel,
  output logic                 AluWF,
  input  logic [31:0]          AluOut,
  input  logic [3:0]           AluFlags
);

  localparam int unsigned W         = 32;
  localparam int unsigned FW        = 5;
  localparam int unsigned CARRY_BIT = 2;

  localparam logic [FW-1:0] FS_IDLE = 5'b10000;
  localparam logic [FW-1:0] FS_ADD  = 5'b10100;
  localparam logic [FW-1:0] FS_LSL  = 5'b11011;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   acc, acc_nxt;
  logic [W-1:0]   mcand, mcand_nxt;
  logic [W-1:0]   mplr, mplr_nxt;
  logic           lost, lost_nxt, lost_now;
  logic           ovf, ovf_nxt;
  logic           prev_add, prev_shift;
  logic           ready_q, done_q, overflow_q;
  logic [W-1:0]   product_q;
  logic [W-1:0]   mplr_shr;
  logic           carry;
  logic           unused_bits;

  assign carry       = AluFlags[CARRY_BIT];
  assign mplr_shr    = mplr >> 1;
  assign unused_bits = ^{AluFlags[3], AluFlags[1:0], mplr[0]};

  assign ctl.Ready    = ready_q;
  assign ctl.Done     = done_q;
  assign ctl.Product  = product_q;
  assign ctl.Overflow = overflow_q;

  // Next-state and datapath updates; flags seen here were written by the
  // previous ALU step, so prev_add/prev_shift qualify which carry they carry.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mcand_nxt = mcand;
    mplr_nxt  = mplr;
    lost_nxt  = lost;
    ovf_nxt   = ovf;
    lost_now  = lost | (prev_shift & carry);
    case (state)
      S_IDLE: begin
        if (ctl.Start) begin
          mcand_nxt = ctl.OpA;
          mplr_nxt  = ctl.OpB;
          acc_nxt   = '0;
          lost_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
          if (ctl.OpB == '0)   state_nxt = S_DONE;
          else if (ctl.OpB[0]) state_nxt = S_ADD;
          else                 state_nxt = S_SHIFT;
        end
      end
      S_ADD: begin
        acc_nxt   = AluOut;
        ovf_nxt   = ovf | lost_now;
        lost_nxt  = lost_now;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        mcand_nxt = AluOut;
        mplr_nxt  = mplr_shr;
        if (prev_add)   ovf_nxt  = ovf | carry;
        if (prev_shift) lost_nxt = lost | carry;
        if (mplr_shr == '0)  state_nxt = S_DONE;
        else if (mplr[1])    state_nxt = S_ADD;
        else                 state_nxt = S_SHIFT;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs derived from the upcoming state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplr       <= '0;
      lost       <= 1'b0;
      ovf        <= 1'b0;
      prev_add   <= 1'b0;
      prev_shift <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      AluA       <= '0;
      AluB       <= '0;
      AluFunSel  <= FS_IDLE;
      AluWF      <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      mcand      <= mcand_nxt;
      mplr       <= mplr_nxt;
      lost       <= lost_nxt;
      ovf        <= ovf_nxt;
      prev_add   <= (state == S_ADD);
      prev_shift <= (state == S_SHIFT);
      ready_q    <= (state_nxt == S_IDLE);
      done_q     <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) begin
        product_q  <= acc_nxt;
        overflow_q <= ovf_nxt;
      end
      AluA  <= (state_nxt == S_SHIFT) ? mcand_nxt : acc_nxt;
      AluB  <= mcand_nxt;
      AluWF <= (state_nxt == S_ADD) || (state_nxt == S_SHIFT);
      case (state_nxt)
        S_ADD:   AluFunSel <= FS_ADD;
        S_SHIFT: AluFunSel <= FS_LSL;
        default: AluFunSel <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU alongside.
module tb_alu_mul_sequencer;

  localparam logic [4:0] FS_IDLE = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_LSL  = 5'b11011;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] AluA, AluB, AluOut;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [3:0]  AluFlags;
  logic        alu_carry;

  alu_mul_sequencer_if ctl();

  alu_mul_sequencer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ctl       (ctl),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluFunSel (AluFunSel),
    .AluWF     (AluWF),
    .AluOut    (AluOut),
    .AluFlags  (AluFlags)
  );

  always #5 Clock = ~Clock;

  // ALU: combinational result, flags {Z,C,N,O} registered when WF is high.
  always_comb begin
    alu_carry = 1'b0;
    AluOut    = AluA;
    case (AluFunSel)
      FS_ADD: {alu_carry, AluOut} = {1'b0, AluA} + {1'b0, AluB};
      FS_LSL: begin
        AluOut    = AluA << 1;
        alu_carry = AluA[31];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)     AluFlags <= '0;
    else if (AluWF) AluFlags <= {AluOut == 32'h0, alu_carry, AluOut[31], 1'b0};
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] product;
    logic        ovf;
    int          lat;
    int          adds;
    int          shifts;
    time         t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: exact 64-bit product and operation counts from the multiplier bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] full;
    int          h;
    int          p;
    full = 64'(a) * 64'(b);
    p    = $countones(b);
    h    = -1;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    e.a       = a;
    e.b       = b;
    e.product = full[31:0];
    e.ovf     = |full[63:32];
    e.adds    = p;
    e.shifts  = h + 1;
    e.lat     = (h + 1) + p + 1;
    e.t_acc   = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: observes the DUT each falling edge and retires scoreboard entries on Done.
  int          adds_cnt = 0;
  int          shifts_cnt = 0;
  int          wf_cnt = 0;
  logic        done_prev = 1'b0;
  logic [31:0] last_product = '0;
  logic        last_ovf = 1'b0;
  exp_t        cur;
  int          lat;

  always @(negedge Clock) begin
    if (!Reset) begin
      exp_q.delete();
      adds_cnt     = 0;
      shifts_cnt   = 0;
      wf_cnt       = 0;
      done_prev    = 1'b0;
      last_product = '0;
      last_ovf     = 1'b0;
      chk("reset_ready",    64'(ctl.Ready),    64'(1));
      chk("reset_done",     64'(ctl.Done),     64'(0));
      chk("reset_product",  64'(ctl.Product),  64'(0));
      chk("reset_overflow", 64'(ctl.Overflow), 64'(0));
      chk("reset_wf",       64'(AluWF),        64'(0));
      chk("reset_funsel",   64'(AluFunSel),    64'(FS_IDLE));
      chk("reset_alu_a",    64'(AluA),         64'(0));
      chk("reset_alu_b",    64'(AluB),         64'(0));
    end else begin
      if (AluWF) wf_cnt++;
      if (AluWF && AluFunSel == FS_ADD) adds_cnt++;
      if (AluWF && AluFunSel == FS_LSL) shifts_cnt++;
      if (ctl.Ready) chk("idle_wf", 64'(AluWF), 64'(0));
      if (done_prev) chk("ready_after_done", 64'(ctl.Ready), 64'(1));
      else if (exp_q.size() != 0) chk("busy_ready", 64'(ctl.Ready), 64'(0));
      if (ctl.Done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(ctl.Done), 64'(0));
        end else begin
          cur = exp_q.pop_front();
          lat = int'(($time - cur.t_acc - 5) / 10) + 1;
          chk("product",  64'(ctl.Product),  64'(cur.product));
          chk("overflow", 64'(ctl.Overflow), 64'(cur.ovf));
          chk("latency",  64'(lat),          64'(cur.lat));
          chk("add_steps",   64'(adds_cnt),   64'(cur.adds));
          chk("shift_steps", 64'(shifts_cnt), 64'(cur.shifts));
          chk("wf_cycles",   64'(wf_cnt),     64'(cur.adds + cur.shifts));
        end
        adds_cnt   = 0;
        shifts_cnt = 0;
        wf_cnt     = 0;
      end else begin
        chk("product_hold",  64'(ctl.Product),  64'(last_product));
        chk("overflow_hold", 64'(ctl.Overflow), 64'(last_ovf));
        if (exp_q.size() != 0 && ($time - exp_q[0].t_acc) > 1000) begin
          chk("done_timeout", 64'(ctl.Done), 64'(1));
          void'(exp_q.pop_front());
        end
      end
      last_product = ctl.Product;
      last_ovf     = ctl.Overflow;
      done_prev    = ctl.Done;
    end
  end

  // Driver: issue one request once Ready is seen; optionally poke Start mid-run.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit glitch);
    exp_t e;
    int   guard;
    guard = 0;
    while (!ctl.Ready && guard < 400) begin
      @(posedge Clock); #1;
      guard++;
    end
    if (!ctl.Ready) begin
      $display("FAIL ready_wait: Ready still 0 after %0d cycles", guard);
      $fatal(1, "bench stopped");
    end
    ctl.Start = 1'b1;
    ctl.OpA   = a;
    ctl.OpB   = b;
    e = model(a, b);
    @(posedge Clock);
    e.t_acc = $time;
    exp_q.push_back(e);
    #1;
    ctl.Start = 1'b0;
    ctl.OpA   = $urandom;
    ctl.OpB   = $urandom;
    if (glitch) begin
      @(posedge Clock); #1;
      ctl.Start = 1'b1;
      ctl.OpA   = 32'h0000_1234;
      ctl.OpB   = 32'h0000_0005;
      @(posedge Clock); #1;
      ctl.Start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge Clock); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL idle_wait: scoreboard still holds %0d entries", exp_q.size());
      $fatal(1, "bench stopped");
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    ctl.Start = 1'b0;
    ctl.OpA   = '0;
    ctl.OpB   = '0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    issue(32'd5, 32'd3, 1'b0);                   wait_idle();
    issue(32'hFFFF_FFFF, 32'd0, 1'b0);           wait_idle();
    issue(32'h6000_0000, 32'd3, 1'b0);           wait_idle();
    issue(32'h8000_0000, 32'd2, 1'b0);           wait_idle();
    issue(32'hFFFF_FFFF, 32'd3, 1'b1);           wait_idle();

    // Back-to-back requests taken in the Ready cycle right after Done.
    issue(32'd9, 32'd6, 1'b0);
    issue(32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(32'd0, 32'hFFFF_FFFF, 1'b0);           wait_idle();

    // Abort a long run with Reset during work cycle 10.
    issue(32'd7, 32'h8000_0000, 1'b0);
    repeat (9) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    issue(32'd2, 32'd2, 1'b0);                   wait_idle();

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 4 == 0) a = a >> $urandom_range(0, 31);
      issue(a, b, 1'b0);
      if (i % 3 != 0) wait_idle();
    end
    wait_idle();

    repeat (3) @(posedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
